// File: rtl/kernel_bc_write_back_ctrl.sv
// Write-back controller: pops a start token, streams num_items {addr,data} records
// onto a registered valid/ready write channel, then pulses ap_done.
module kernel_bc_write_back_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             start_empty_n,
  output logic                             start_read,
  input  logic [CNT_WIDTH-1:0]             num_items,
  input  logic                             in_empty_n,
  output logic                             in_read,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] in_dout,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  output logic [ADDR_WIDTH-1:0]            m_waddr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic                             ap_done,
  output logic                             ap_idle,
  output logic [CNT_WIDTH-1:0]             items_written
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]    items_q, items_d;
  logic                    wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    idle_q, idle_d;
  logic                    slot_free_s;
  logic                    start_read_s;
  logic                    in_read_s;

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    issued_d     = issued_q;
    items_d      = items_q;
    wvalid_d     = wvalid_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    start_read_s = 1'b0;
    in_read_s    = 1'b0;
    slot_free_s  = !wvalid_q || m_wready;

    if (wvalid_q && m_wready) begin
      items_d = items_q + CNT_ONE;
    end else begin
      items_d = items_q;
    end

    case (state_q)
      S_IDLE: begin
        start_read_s = start_empty_n;
        if (start_empty_n) begin
          remaining_d = num_items;
          issued_d    = '0;
          items_d     = '0;
          state_d     = (num_items == '0) ? S_DONE : S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        in_read_s = in_empty_n && slot_free_s && (issued_q != remaining_q);
        if (in_read_s) begin
          wvalid_d = 1'b1;
          waddr_d  = in_dout[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          wdata_d  = in_dout[DATA_WIDTH-1:0];
          issued_d = issued_q + CNT_ONE;
        end else if (slot_free_s) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        // Leave as soon as the final record has been popped
        if (issued_d == remaining_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (slot_free_s) begin
          wvalid_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    idle_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      issued_q    <= '0;
      items_q     <= '0;
      wvalid_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      items_q     <= items_d;
      wvalid_q    <= wvalid_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
    end
  end

  assign start_read    = start_read_s;
  assign in_read       = in_read_s;
  assign m_wvalid      = wvalid_q;
  assign m_waddr       = waddr_q;
  assign m_wdata       = wdata_q;
  assign ap_done       = done_q;
  assign ap_idle       = idle_q;
  assign items_written = items_q;

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// Scoreboard bench for kernel_bc_write_back_ctrl: directed jobs feed expected
// writes/completions into queues that a negedge monitor checks.
`timescale 1ns/1ps
module tb_kernel_bc_write_back_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b1;
  logic              start_empty_n, start_read;
  logic [CW-1:0]     num_items;
  logic              in_empty_n, in_read;
  logic [AW+DW-1:0]  in_dout;
  logic              m_wvalid, m_wready;
  logic [AW-1:0]     m_waddr;
  logic [DW-1:0]     m_wdata;
  logic              ap_done, ap_idle;
  logic [CW-1:0]     items_written;

  kernel_bc_write_back_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .start_empty_n(start_empty_n), .start_read(start_read), .num_items(num_items),
    .in_empty_n(in_empty_n), .in_read(in_read), .in_dout(in_dout),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .ap_done(ap_done), .ap_idle(ap_idle), .items_written(items_written)
  );

  always #5 ap_clk = ~ap_clk;

  logic [AW+DW-1:0] rec_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [CW-1:0]    tok_q[$];
  logic [CW-1:0]    exp_done_q[$];
  logic             stream_en = 1'b1;

  int total = 0, bad = 0, cyc = 0, done_cnt = 0, wr_cnt = 0, last_pop_cyc = 0;
  logic pop_rec_s = 1'b0, pop_tok_s = 1'b0, end_req = 1'b0, end_ack = 1'b0;
  logic prev_valid_s = 1'b0, prev_ready_s = 1'b0, prev_in_read_s = 1'b0, prev_done_s = 1'b0;
  logic [AW-1:0]    prev_addr_s = '0;
  logic [DW-1:0]    prev_data_s = '0;
  logic [AW+DW-1:0] prev_dout_s = '0;

  // Monitor: samples on the falling edge, compares against the scoreboard
  always @(negedge ap_clk) begin
    logic [AW+DW-1:0] exp_w;
    logic [CW-1:0]    exp_n;
    logic             exp_sr;
    int               exp_gap;
    cyc++;
    pop_rec_s = 1'b0;
    pop_tok_s = 1'b0;
    if (!ap_rst_n) begin
      total++;
      if (m_wvalid !== 1'b0 || m_waddr !== '0 || m_wdata !== '0 || ap_done !== 1'b0 ||
          ap_idle !== 1'b1 || items_written !== '0 || start_read !== 1'b0 || in_read !== 1'b0) begin
        bad++;
        $display("FAIL reset_vals: got wvalid=%b waddr=%h wdata=%h done=%b idle=%b items=%0d, want 0 0 0 0 1 0",
                 m_wvalid, m_waddr, m_wdata, ap_done, ap_idle, items_written);
      end
      prev_valid_s = 1'b0; prev_ready_s = 1'b0; prev_in_read_s = 1'b0; prev_done_s = 1'b0;
    end else begin
      total++;
      if (prev_valid_s && !prev_ready_s) begin
        if (m_wvalid !== 1'b1 || m_waddr !== prev_addr_s || m_wdata !== prev_data_s) begin
          bad++;
          $display("FAIL hold_stable: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                   m_wvalid, m_waddr, m_wdata, prev_addr_s, prev_data_s);
        end
      end else if (prev_in_read_s) begin
        if (m_wvalid !== 1'b1 || m_waddr !== prev_dout_s[AW+DW-1:DW] || m_wdata !== prev_dout_s[DW-1:0]) begin
          bad++;
          $display("FAIL load_rec: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                   m_wvalid, m_waddr, m_wdata, prev_dout_s[AW+DW-1:DW], prev_dout_s[DW-1:0]);
        end
      end else if (m_wvalid !== 1'b0) begin
        bad++;
        $display("FAIL valid_drop: got wvalid=%b want 0", m_wvalid);
      end

      total++;
      exp_sr = ap_idle ? start_empty_n : 1'b0;
      if (start_read !== exp_sr) begin
        bad++;
        $display("FAIL start_read: got %b want %b (idle=%b)", start_read, exp_sr, ap_idle);
      end

      if (in_read) begin
        total++;
        if (!in_empty_n || (m_wvalid && !m_wready)) begin
          bad++;
          $display("FAIL in_read_rule: got in_read=1 with empty_n=%b wvalid=%b wready=%b, want no pop",
                   in_empty_n, m_wvalid, m_wready);
        end
      end

      if (m_wvalid && m_wready) begin
        total++;
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexp: got a=%h d=%h want no write", m_waddr, m_wdata);
        end else begin
          exp_w = exp_wr_q.pop_front();
          if ({m_waddr, m_wdata} !== exp_w) begin
            bad++;
            $display("FAIL write_data: got a=%h d=%h want a=%h d=%h",
                     m_waddr, m_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
          end
        end
      end

      if (ap_done) begin
        total++;
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexp: got ap_done=1 want 0");
        end else begin
          exp_n   = exp_done_q.pop_front();
          exp_gap = (exp_n == '0) ? 1 : 2;
          if (items_written !== exp_n || (cyc - last_pop_cyc) != exp_gap || ap_idle !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got items=%0d gap=%0d idle=%b want items=%0d gap=%0d idle=0",
                     items_written, cyc - last_pop_cyc, ap_idle, exp_n, exp_gap);
          end
        end
      end

      if (prev_done_s) begin
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
          bad++;
          $display("FAIL after_done: got idle=%b done=%b want idle=1 done=0", ap_idle, ap_done);
        end
      end

      if (in_read || start_read) last_pop_cyc = cyc;
      pop_rec_s      = in_read;
      pop_tok_s      = start_read;
      prev_valid_s   = m_wvalid;
      prev_ready_s   = m_wready;
      prev_in_read_s = in_read;
      prev_done_s    = ap_done;
      prev_addr_s    = m_waddr;
      prev_data_s    = m_wdata;
      prev_dout_s    = in_dout;
    end

    if (end_req && !end_ack) begin
      total++;
      if (exp_wr_q.size() != 0 || exp_done_q.size() != 0 || done_cnt != 7) begin
        bad++;
        $display("FAIL end_state: got pending_wr=%0d pending_done=%0d dones=%0d want 0 0 7",
                 exp_wr_q.size(), exp_done_q.size(), done_cnt);
      end
      end_ack = 1'b1;
    end
  end

  task automatic drive();
    in_empty_n    = stream_en && (rec_q.size() != 0);
    in_dout       = (rec_q.size() != 0) ? rec_q[0] : '0;
    start_empty_n = (tok_q.size() != 0);
    num_items     = (tok_q.size() != 0) ? tok_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (pop_rec_s && rec_q.size() != 0) void'(rec_q.pop_front());
    if (pop_tok_s && tok_q.size() != 0) void'(tok_q.pop_front());
    #1;
    drive();
  endtask

  task automatic push_rec(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rec_q.push_back({a, d});
    exp_wr_q.push_back({a, d});
  endtask

  task automatic push_tok(input logic [CW-1:0] n);
    tok_q.push_back(n);
    exp_done_q.push_back(n);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && done_cnt < n; i++) tick();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && m_wvalid !== 1'b1; i++) tick();
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 100 && wr_cnt < n; i++) tick();
  endtask

  initial begin
    m_wready = 1'b1;
    drive();
    #1 ap_rst_n = 1'b0;
    repeat (3) tick();
    ap_rst_n = 1'b1;

    // Three records at full rate
    push_rec(32'h10, 32'hA); push_rec(32'h14, 32'hB); push_rec(32'h18, 32'hC);
    push_tok(32'd3); drive();
    wait_done(1);

    // Empty job
    push_tok(32'd0); drive();
    wait_done(2);
    repeat (2) tick();

    // Sink stall right after the first valid
    push_rec(32'h20, 32'h100); push_rec(32'h24, 32'h101);
    push_rec(32'h28, 32'h102); push_rec(32'h2C, 32'h103);
    push_tok(32'd4); drive();
    wait_valid();
    m_wready = 1'b0;
    repeat (5) tick();
    m_wready = 1'b1;
    wait_done(3);

    // Stream runs dry mid-job
    push_rec(32'h30, 32'hDEAD0001); push_tok(32'd2); drive();
    wait_wr(8);
    repeat (3) tick();
    push_rec(32'h34, 32'hDEAD0002); drive();
    wait_done(4);

    // Two queued tokens
    push_rec(32'h40, 32'h1); push_rec(32'h44, 32'h2); push_rec(32'h48, 32'h3);
    push_tok(32'd2); push_tok(32'd1); drive();
    wait_done(6);

    // Reset mid-stream, then a fresh job
    push_rec(32'h50, 32'h5); push_rec(32'h54, 32'h6); push_rec(32'h58, 32'h7);
    push_tok(32'd3); drive();
    wait_valid();
    ap_rst_n = 1'b0;
    rec_q.delete(); tok_q.delete(); exp_wr_q.delete(); exp_done_q.delete();
    drive();
    tick();
    ap_rst_n = 1'b1;
    tick();
    push_rec(32'h60, 32'h55); push_tok(32'd1); drive();
    wait_done(7);
    repeat (2) tick();

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
